// File: rtl/pwm_spi_reg_ctrl.sv
// pwm_spi_reg_ctrl: SPI command decoder and shadow/active register scheduler
// for the PWM channel bank. Each CS-framed 6-byte transaction is one register
// read or write. Shadow values move to the active registers only on a PWM
// period boundary, and only after software has armed a commit.
module pwm_spi_reg_ctrl #(
    parameter int NUM_CH = 6,
    parameter int DW     = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CS,
    input  logic [5:0]           RX_STROBE,
    input  logic [7:0]           RX0,
    input  logic [7:0]           RX2,
    input  logic [7:0]           RX3,
    input  logic [7:0]           RX4,
    input  logic [7:0]           RX5,
    output logic [DW-1:0]        RDATA,
    input  logic                 PERIOD_END,
    output logic [NUM_CH*DW-1:0] DUTY,
    output logic [DW-1:0]        PERIOD,
    output logic                 PWM_EN,
    output logic                 WR_PULSE
);

    // Frame decoder states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] ADDR_PERIOD = 4'hE;
    localparam logic [3:0] ADDR_CTRL   = 4'hF;

    // Frame decoder state.
    logic [1:0]    state;
    logic [2:0]    byte_idx;    // next data byte expected while in DATA (2..5)
    logic          cmd_wr;
    logic [3:0]    cmd_addr;
    logic [DW-1:0] data_q;

    // Register file.
    logic [DW-1:0] shadow_duty [NUM_CH];
    logic [DW-1:0] active_duty [NUM_CH];
    logic [DW-1:0] shadow_period;
    logic [DW-1:0] active_period;
    logic          en;
    logic          pending;
    logic          ferr;

    // Decode helpers.
    logic [5:0]    exp_strobe;
    logic          cs_abort;
    logic          bad_strobe;
    logic          frame_start;
    logic          truncated;
    logic          wr_en;
    logic          ctrl_wr;
    logic          arm_commit;
    logic          do_commit;
    logic [DW-1:0] rd_mux;

    // Command bits [6:4] carry no meaning.
    logic rx0_unused;
    assign rx0_unused = ^RX0[6:4];

    // Decode which strobe is legal now and what the incoming strobes mean.
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        exp_strobe = 6'b000000;
        case (state)
            ST_IDLE: exp_strobe = 6'b000001;
            ST_HDR:  exp_strobe = 6'b000010;
            ST_DATA: exp_strobe = 6'b000001 << byte_idx;
            default: exp_strobe = 6'b000000;
        endcase
        // CS is ignored during DONE so a frame that ends with CS rising right
        // after byte 5 still commits its write.
        cs_abort    = CS && (state != ST_DONE);
        truncated   = CS && ((state == ST_HDR) || (state == ST_DATA));
        bad_strobe  = !cs_abort && ((RX_STROBE & ~exp_strobe) != 6'b000000);
        frame_start = !cs_abort && RX_STROBE[0];
        wr_en       = (state == ST_DONE) && cmd_wr;
        ctrl_wr     = wr_en && (cmd_addr == ADDR_CTRL);
        arm_commit  = ctrl_wr && data_q[1];
        // An arming write coinciding with PERIOD_END transfers on that same edge.
        do_commit   = PERIOD_END && (pending || arm_commit);
    end

    // Readback mux, addressed by the command byte arriving this cycle.
    always_comb begin
        rd_mux = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (RX0[3:0] == 4'(n)) rd_mux = shadow_duty[n];
        end
        if (RX0[3:0] == ADDR_PERIOD) rd_mux = shadow_period;
        if (RX0[3:0] == ADDR_CTRL)   rd_mux = {{(DW-3){1'b0}}, ferr, pending, en};
    end

    // Frame sequencing: track byte position, latch command and data bytes.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, matching the hardware.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            byte_idx <= 3'd2;
            cmd_wr   <= 1'b0;
            cmd_addr <= 4'd0;
            data_q   <= '0;
        end else if (cs_abort) begin
            state <= ST_IDLE;
        end else if (frame_start) begin
            // Byte 0 always (re)starts a frame, even mid-frame.
            cmd_wr   <= RX0[7];
            cmd_addr <= RX0[3:0];
            state    <= ST_HDR;
        end else if (bad_strobe) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_HDR: begin
                    if (RX_STROBE[1]) begin
                        state    <= ST_DATA;
                        byte_idx <= 3'd2;
                    end
                end
                ST_DATA: begin
                    if ((RX_STROBE & exp_strobe) != 6'b000000) begin
                        case (byte_idx)
                            3'd2:    data_q[31:24] <= RX2;
                            3'd3:    data_q[23:16] <= RX3;
                            3'd4:    data_q[15:8]  <= RX4;
                            default: data_q[7:0]   <= RX5;
                        endcase
                        if (byte_idx == 3'd5) state <= ST_DONE;
                        else                  byte_idx <= byte_idx + 3'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register writes, commit transfer, control flags and readback.
    // NOTE: shadow/active arrays are flops, not RAM, and must read 0 out of reset, so every entry is cleared explicitly.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int n = 0; n < NUM_CH; n++) begin
                shadow_duty[n] <= '0;
                active_duty[n] <= '0;
            end
            shadow_period <= '0;
            active_period <= '0;
            en            <= 1'b0;
            pending       <= 1'b0;
            ferr          <= 1'b0;
            RDATA         <= '0;
            WR_PULSE      <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_en && (cmd_addr == 4'(n))) shadow_duty[n] <= data_q;
            end
            if (wr_en && (cmd_addr == ADDR_PERIOD)) shadow_period <= data_q;

            // Transfer sees shadow values from before this edge.
            if (do_commit) begin
                for (int n = 0; n < NUM_CH; n++) active_duty[n] <= shadow_duty[n];
                active_period <= shadow_period;
            end

            if (ctrl_wr) en <= data_q[0];

            if (do_commit)       pending <= 1'b0;
            else if (arm_commit) pending <= 1'b1;

            // A new error wins over a same-cycle clear so no error is lost.
            if (bad_strobe || truncated)  ferr <= 1'b1;
            else if (ctrl_wr && data_q[2]) ferr <= 1'b0;

            if (frame_start) RDATA <= rd_mux;

            WR_PULSE <= wr_en;
        end
    end

    // Flatten the active duty registers onto the output bus.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_duty
        assign DUTY[n*DW +: DW] = active_duty[n];
    end

    assign PERIOD = active_period;
    assign PWM_EN = en;

endmodule

// File: tb/tb_pwm_spi_reg_ctrl.sv
// Directed bench for pwm_spi_reg_ctrl: frames are driven byte by byte and the
// register/commit behaviour is compared against hand-computed values.
module tb_pwm_spi_reg_ctrl;

    localparam int NUM_CH = 6;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              CS;
    logic [5:0]        RX_STROBE;
    logic [7:0]        RX0, RX2, RX3, RX4, RX5;
    logic [31:0]       RDATA;
    logic              PERIOD_END;
    logic [NUM_CH*32-1:0] DUTY;
    logic [31:0]       PERIOD;
    logic              PWM_EN;
    logic              WR_PULSE;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    pwm_spi_reg_ctrl #(.NUM_CH(NUM_CH), .DW(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .CS(CS), .RX_STROBE(RX_STROBE),
        .RX0(RX0), .RX2(RX2), .RX3(RX3), .RX4(RX4), .RX5(RX5),
        .RDATA(RDATA), .PERIOD_END(PERIOD_END), .DUTY(DUTY),
        .PERIOD(PERIOD), .PWM_EN(PWM_EN), .WR_PULSE(WR_PULSE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (WR_PULSE === 1'b1) wr_cnt++;
    endtask

    task automatic strobe_byte(input int k);
        RX_STROBE = 6'b000001 << k;
        tick();
        RX_STROBE = 6'b000000;
        tick();
    endtask

    task automatic load_bytes(input logic [7:0] cmd, input logic [31:0] d);
        RX0 = cmd;
        RX2 = d[31:24];
        RX3 = d[23:16];
        RX4 = d[15:8];
        RX5 = d[7:0];
    endtask

    // Drive bytes 0..nbytes-1 of a frame, then deselect.
    task automatic frame(input logic [7:0] cmd, input logic [31:0] d, input int nbytes);
        CS = 1'b0;
        tick();
        load_bytes(cmd, d);
        for (int k = 0; k < nbytes; k++) strobe_byte(k);
        CS = 1'b1;
        tick();
        tick();
    endtask

    // Full frame whose DONE cycle coincides with a PERIOD_END pulse.
    task automatic frame_with_period_end(input logic [7:0] cmd, input logic [31:0] d);
        CS = 1'b0;
        tick();
        load_bytes(cmd, d);
        for (int k = 0; k < 5; k++) strobe_byte(k);
        RX_STROBE = 6'b100000;
        tick();
        RX_STROBE  = 6'b000000;
        PERIOD_END = 1'b1;
        tick();
        PERIOD_END = 1'b0;
        CS = 1'b1;
        tick();
        tick();
    endtask

    task automatic pulse_period_end();
        PERIOD_END = 1'b1;
        tick();
        PERIOD_END = 1'b0;
        tick();
    endtask

    task automatic read_reg(input logic [3:0] addr, input string tag, input logic [31:0] exp);
        frame({4'h0, addr}, 32'h0, 6);
        check(tag, RDATA, exp);
    endtask

    initial begin
        RST_N = 1'b0; CS = 1'b1; RX_STROBE = '0; PERIOD_END = 1'b0;
        RX0 = '0; RX2 = '0; RX3 = '0; RX4 = '0; RX5 = '0;
        tick(); tick();
        check("rst_rdata",  RDATA, 32'h0);
        check("rst_period", PERIOD, 32'h0);
        check("rst_duty",   {31'b0, |DUTY}, 32'h0);
        check("rst_pwm_en", {31'b0, PWM_EN}, 32'h0);
        check("rst_wr_pulse", {31'b0, WR_PULSE}, 32'h0);
        RST_N = 1'b1;
        tick();

        // 1: shadow write and readback; active stays 0.
        wr_cnt = 0;
        frame(8'h82, 32'h12345678, 6);
        check("t1_wr_pulse_cnt", wr_cnt, 1);
        read_reg(4'h2, "t1_read_addr2", 32'h12345678);
        check("t1_read_no_pulse", wr_cnt, 1);
        check("t1_duty2_precommit", DUTY[2*32 +: 32], 32'h0);

        // 2: enable + arm, then period boundary commits.
        frame(8'h8F, 32'h3, 6);
        check("t2_pwm_en", {31'b0, PWM_EN}, 32'h1);
        check("t2_duty2_armed", DUTY[2*32 +: 32], 32'h0);
        PERIOD_END = 1'b1;
        tick();
        PERIOD_END = 1'b0;
        check("t2_duty2_committed", DUTY[2*32 +: 32], 32'h12345678);
        read_reg(4'hF, "t2_ctrl", 32'h1);
        frame(8'h83, 32'h33, 6);
        pulse_period_end();
        check("t2_no_pending_no_xfer", DUTY[3*32 +: 32], 32'h0);

        // 3: arm in the same cycle as PERIOD_END.
        frame(8'h8E, 32'h100, 6);
        frame_with_period_end(8'h8F, 32'h3);
        check("t3_period", PERIOD, 32'h100);
        check("t3_duty3", DUTY[3*32 +: 32], 32'h33);
        read_reg(4'hF, "t3_ctrl_pending0", 32'h1);
        // Shadow write racing a transfer: active takes the old shadow value.
        frame(8'h84, 32'h40, 6);
        frame(8'h8F, 32'h3, 6);
        frame_with_period_end(8'h84, 32'h44);
        check("t3_duty4_old_shadow", DUTY[4*32 +: 32], 32'h40);
        read_reg(4'h4, "t3_shadow4_new", 32'h44);
        read_reg(4'hF, "t3_ctrl_after_race", 32'h1);

        // 4: CS rises after byte 3 of a write.
        wr_cnt = 0;
        frame(8'h81, 32'hCAFEBABE, 4);
        check("t4_trunc_no_pulse", wr_cnt, 0);
        read_reg(4'h1, "t4_shadow1_unchanged", 32'h0);
        read_reg(4'hF, "t4_ctrl_ferr", 32'h5);
        frame(8'h8F, 32'h4, 6);
        read_reg(4'hF, "t4_ctrl_cleared", 32'h0);
        check("t4_pwm_en_off", {31'b0, PWM_EN}, 32'h0);

        // 5: byte 0 arrives while in DATA and restarts the frame.
        wr_cnt = 0;
        CS = 1'b0;
        tick();
        load_bytes(8'h85, 32'h11111111);
        for (int k = 0; k < 3; k++) strobe_byte(k);
        load_bytes(8'h80, 32'hA5A5A5A5);
        for (int k = 0; k < 6; k++) strobe_byte(k);
        CS = 1'b1;
        tick();
        tick();
        check("t5_restart_pulse_cnt", wr_cnt, 1);
        read_reg(4'h0, "t5_shadow0", 32'hA5A5A5A5);
        read_reg(4'h5, "t5_shadow5_untouched", 32'h0);
        read_reg(4'hF, "t5_ctrl_ferr", 32'h4);

        // 6: reset mid-frame after a commit.
        frame(8'h8F, 32'h3, 6);
        pulse_period_end();
        check("t6_duty0_committed", DUTY[0 +: 32], 32'hA5A5A5A5);
        check("t6_pwm_en_on", {31'b0, PWM_EN}, 32'h1);
        CS = 1'b0;
        tick();
        load_bytes(8'h81, 32'h77);
        for (int k = 0; k < 3; k++) strobe_byte(k);
        RST_N = 1'b0;
        tick();
        check("t6_rst_duty",   {31'b0, |DUTY}, 32'h0);
        check("t6_rst_period", PERIOD, 32'h0);
        check("t6_rst_pwm_en", {31'b0, PWM_EN}, 32'h0);
        check("t6_rst_rdata",  RDATA, 32'h0);
        check("t6_rst_wr_pulse", {31'b0, WR_PULSE}, 32'h0);
        RST_N = 1'b1;
        CS = 1'b1;
        tick();
        wr_cnt = 0;
        frame(8'h81, 32'h77, 6);
        check("t6_post_pulse_cnt", wr_cnt, 1);
        read_reg(4'h1, "t6_post_shadow1", 32'h77);
        read_reg(4'h0, "t6_post_shadow0_reset", 32'h0);
        read_reg(4'hF, "t6_post_ctrl", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
